// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: issues one memory read at a time, holds the returned
// word for the decode stage, and follows taken branches or stops on halt.
module instr_fetch #(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned INSTR_W  = 9,
    parameter int unsigned START_PC = 0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic               halt_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [2:0]         opcode_o,
    output logic [PC_W-1:0]    instr_pc_o,
    input  logic               dec_ready_i,
    input  logic               br_taken_i,
    input  logic [PC_W-1:0]    br_target_i,
    output logic               done_o
);

    // state    | meaning
    // S_IDLE   | waiting for start
    // S_REQ    | read request outstanding at pc_q
    // S_HOLD   | instruction offered downstream, waiting for dec_ready_i
    // S_HALTED | stopped; only reset leaves this state
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_HOLD   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    localparam logic [PC_W-1:0] START_PC_L = PC_W'(START_PC);
    localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);

    state_e             state_q,     state_d;
    logic [PC_W-1:0]    pc_q,        pc_d;
    logic [INSTR_W-1:0] instr_q,     instr_d;
    logic [PC_W-1:0]    instr_pc_q,  instr_pc_d;
    logic               halt_pend_q, halt_pend_d;
    logic               halt_eff;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            pc_q        <= START_PC_L;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // A halt pulse seen while busy is remembered so it still takes effect
    // when the outstanding response or handshake finally arrives.
    assign halt_eff = halt_i | halt_pend_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        halt_pend_d = halt_pend_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_REQ;
                    pc_d    = START_PC_L;
                end
            end
            S_REQ: begin
                if (halt_i) begin
                    halt_pend_d = 1'b1;
                end
                if (imem_rvalid_i) begin
                    if (halt_eff) begin
                        state_d    = S_HALTED;
                        instr_d    = '0;
                        instr_pc_d = '0;
                    end else begin
                        state_d    = S_HOLD;
                        instr_d    = imem_rdata_i;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + PC_ONE;
                    end
                end
            end
            S_HOLD: begin
                if (halt_i) begin
                    halt_pend_d = 1'b1;
                end
                if (dec_ready_i) begin
                    if (halt_eff) begin
                        state_d    = S_HALTED;
                        instr_d    = '0;
                        instr_pc_d = '0;
                    end else begin
                        state_d = S_REQ;
                        if (br_taken_i) begin
                            pc_d = br_target_i;
                        end
                    end
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req_o    = (state_q == S_REQ);
    assign imem_addr_o   = (state_q == S_REQ) ? pc_q : '0;
    assign instr_valid_o = (state_q == S_HOLD);
    assign instr_o       = instr_q;
    assign opcode_o      = instr_q[INSTR_W-1 -: 3];
    assign instr_pc_o    = instr_pc_q;
    assign done_o        = (state_q == S_HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, variable latency, stall,
// branch with address wrap, halt in REQ and HOLD, and reset mid-fetch.
module tb_instr_fetch;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       halt;
    logic       imem_req;
    logic [9:0] imem_addr;
    logic       imem_rvalid;
    logic [8:0] imem_rdata;
    logic       instr_valid;
    logic [8:0] instr;
    logic [2:0] opcode;
    logic [9:0] instr_pc;
    logic       dec_ready;
    logic       br_taken;
    logic [9:0] br_target;
    logic       done;

    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .halt_i        (halt),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .opcode_o      (opcode),
        .instr_pc_o    (instr_pc),
        .dec_ready_i   (dec_ready),
        .br_taken_i    (br_taken),
        .br_target_i   (br_target),
        .done_o        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; dec_ready = 1'b0; br_taken = 1'b0; br_target = '0;
        #12;
        chk("rst_req",   32'(imem_req), 0);
        chk("rst_addr",  32'(imem_addr), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", 32'(instr), 0);
        chk("rst_op",    32'(opcode), 0);
        chk("rst_ipc",   32'(instr_pc), 0);
        chk("rst_done",  32'(done), 0);
        rst_n = 1'b1;
        tick();

        // sequential fetch, zero-latency memory
        start = 1'b1;
        tick();
        chk("seq_req0",  32'(imem_req), 1);
        chk("seq_addr0", 32'(imem_addr), 0);
        start = 1'b0; imem_rvalid = 1'b1; imem_rdata = 9'h011; dec_ready = 1'b1;
        tick();
        chk("seq_valid0", 32'(instr_valid), 1);
        chk("seq_ipc0",   32'(instr_pc), 0);
        chk("seq_instr0", 32'(instr), 32'h011);
        chk("seq_noreq0", 32'(imem_req), 0);
        imem_rdata = 9'h022;
        tick();
        chk("seq_addr1", 32'(imem_addr), 1);
        tick();
        chk("seq_ipc1",   32'(instr_pc), 1);
        chk("seq_instr1", 32'(instr), 32'h022);
        imem_rdata = 9'h033;
        tick();
        chk("seq_addr2", 32'(imem_addr), 2);
        tick();
        chk("seq_ipc2",   32'(instr_pc), 2);
        chk("seq_instr2", 32'(instr), 32'h033);

        // three-cycle memory latency
        imem_rvalid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lat_req",   32'(imem_req), 1);
            chk("lat_addr",  32'(imem_addr), 3);
            chk("lat_valid", 32'(instr_valid), 0);
            if (i < 2) tick();
        end
        imem_rvalid = 1'b1; imem_rdata = 9'b101_000011; dec_ready = 1'b0;
        tick();
        imem_rvalid = 1'b0;
        chk("lat_valid_rise", 32'(instr_valid), 1);

        // downstream stall
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", 32'(instr_valid), 1);
            chk("stall_instr", 32'(instr), 32'h143);
            chk("stall_op",    32'(opcode), 5);
            chk("stall_ipc",   32'(instr_pc), 3);
            chk("stall_req",   32'(imem_req), 0);
            tick();
        end

        // taken branch, then run through the top of the address space
        dec_ready = 1'b1; br_taken = 1'b1; br_target = 10'h3F0;
        tick();
        chk("br_addr", 32'(imem_addr), 32'h3F0);
        imem_rvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            br_taken = 1'b1; br_target = 10'h155; imem_rdata = 9'(i);
            chk("wrap_addr", 32'(imem_addr), 32'h3F0 + 32'(i));
            tick();
            br_taken = 1'b0;
            chk("wrap_ipc",   32'(instr_pc), 32'h3F0 + 32'(i));
            chk("wrap_instr", 32'(instr), 32'(i));
            tick();
        end
        chk("wrap_zero", 32'(imem_addr), 0);
        chk("wrap_req",  32'(imem_req), 1);

        // halt during REQ with the response two cycles later
        imem_rvalid = 1'b0; halt = 1'b1;
        tick();
        chk("hreq_req", 32'(imem_req), 1);
        halt = 1'b0;
        tick();
        chk("hreq_req2", 32'(imem_req), 1);
        imem_rvalid = 1'b1; imem_rdata = 9'h1FF;
        tick();
        imem_rvalid = 1'b0;
        chk("hreq_done",  32'(done), 1);
        chk("hreq_valid", 32'(instr_valid), 0);
        chk("hreq_instr", 32'(instr), 0);
        chk("hreq_ipc",   32'(instr_pc), 0);
        chk("hreq_addr",  32'(imem_addr), 0);
        start = 1'b1; halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halted_done", 32'(done), 1);
            chk("halted_req",  32'(imem_req), 0);
        end
        start = 1'b0; halt = 1'b0;

        // halt during HOLD waits for the handshake; branch on it is ignored
        rst_n = 1'b0;
        #2;
        chk("rst2_done", 32'(done), 0);
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0; imem_rvalid = 1'b1; imem_rdata = 9'h0AB; dec_ready = 1'b0;
        tick();
        imem_rvalid = 1'b0; halt = 1'b1; br_taken = 1'b1; br_target = 10'h100;
        tick();
        chk("hhold_valid", 32'(instr_valid), 1);
        chk("hhold_done",  32'(done), 0);
        halt = 1'b0; dec_ready = 1'b1;
        tick();
        br_taken = 1'b0;
        chk("hhold_done2", 32'(done), 1);
        chk("hhold_req",   32'(imem_req), 0);

        // reset while a request is outstanding
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rmid_req_pre", 32'(imem_req), 1);
        rst_n = 1'b0;
        #1;
        chk("rmid_req_drop", 32'(imem_req), 0);
        #1;
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rmid_valid", 32'(instr_valid), 0);
            chk("rmid_req",   32'(imem_req), 0);
        end
        imem_rvalid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
